// File: rtl/cve2_csr_rmw_ctrl.sv
// Master-side read-modify-write controller for a bank of cve2_csr primitives.
// Optional post-write readback check enabled by defining CVE2_CSR_RMW_READBACK_EN.
module cve2_csr_rmw_ctrl #(
    parameter int unsigned  Width  = 32,
    parameter int unsigned  NumCsr = 4,
    localparam int unsigned AddrW  = (NumCsr > 1) ? $clog2(NumCsr) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrW-1:0]        req_addr_i,
    input  logic [1:0]              req_op_i,
    input  logic [Width-1:0]        req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [Width-1:0]        rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic [NumCsr-1:0]       csr_wr_en_o,
    output logic [Width-1:0]        csr_wr_data_o,
    input  logic [NumCsr*Width-1:0] csr_rd_data_i,
    input  logic [NumCsr-1:0]       csr_rd_error_i
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
`ifdef CVE2_CSR_RMW_READBACK_EN
        VERIFY = 3'd3,
`endif
        RESP   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [AddrW-1:0]  addr_q;
    logic [1:0]        op_q;
    logic [Width-1:0]  wdata_q;
    logic [Width-1:0]  old_q;
    logic              err_q;
    logic [NumCsr-1:0] wr_en_q;
    logic [Width-1:0]  wr_data_q;

    logic [Width-1:0]  sel_data;
    logic              sel_err;
    logic [NumCsr-1:0] sel_onehot;
    logic              in_range;
    logic [Width-1:0]  new_val;
    logic              wr_need;
    logic              rd_err;
    logic              do_write;

    // Explicit match per index so an out-of-range address selects nothing.
    always_comb begin
        sel_data   = '0;
        sel_err    = 1'b0;
        sel_onehot = '0;
        in_range   = 1'b0;
        for (int k = 0; k < NumCsr; k++) begin
            if (addr_q == AddrW'(k)) begin
                sel_data      = csr_rd_data_i[k*Width +: Width];
                sel_err       = csr_rd_error_i[k];
                sel_onehot[k] = 1'b1;
                in_range      = 1'b1;
            end
        end
    end

    always_comb begin
        new_val = sel_data;
        case (op_q)
            OP_WRITE: new_val = wdata_q;
            OP_SET:   new_val = sel_data | wdata_q;
            OP_CLEAR: new_val = sel_data & ~wdata_q;
            default:  new_val = sel_data;
        endcase
    end

    assign wr_need  = (op_q == OP_WRITE) ||
                      (((op_q == OP_SET) || (op_q == OP_CLEAR)) && (wdata_q != '0));
    assign rd_err   = !in_range || sel_err;
    assign do_write = wr_need && !rd_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req_valid_i) state_d = READ;
            READ:   state_d = do_write ? WRITE : RESP;
`ifdef CVE2_CSR_RMW_READBACK_EN
            WRITE:  state_d = VERIFY;
            VERIFY: state_d = RESP;
`else
            WRITE:  state_d = RESP;
`endif
            RESP:   if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            op_q      <= OP_READ;
            wdata_q   <= '0;
            old_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            // Write enable is a single-cycle pulse; it is only raised leaving READ.
            wr_en_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        op_q    <= req_op_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                READ: begin
                    old_q <= sel_data;
                    err_q <= rd_err;
                    if (do_write) begin
                        wr_en_q   <= sel_onehot;
                        wr_data_q <= new_val;
                    end
                end
`ifdef CVE2_CSR_RMW_READBACK_EN
                VERIFY: begin
                    if ((sel_data != wr_data_q) || sel_err) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = old_q;
    assign rsp_error_o   = err_q;
    assign csr_wr_en_o   = wr_en_q;
    assign csr_wr_data_o = wr_data_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(csr_wr_en_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(req_valid_i));

endmodule

// File: tb/tb_cve2_csr_rmw_ctrl.sv
// Directed bench for cve2_csr_rmw_ctrl: transaction-level model plus per-cycle compare.
module tb_cve2_csr_rmw_ctrl;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;
`ifdef CVE2_CSR_RMW_READBACK_EN
    localparam int WR_LAT = 3;
    localparam bit RB     = 1'b1;
`else
    localparam int WR_LAT = 2;
    localparam bit RB     = 1'b0;
`endif
    localparam logic [95:0] R3_DATA = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_addr = '0;
    logic [1:0]  req_op = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [31:0] csr_q [4];
    logic [3:0]  csr_err = '0;
    logic [127:0] csr_rd_data;
    bit          ignore_writes = 1'b0;
    logic        preset_en = 1'b0;
    logic [1:0]  preset_idx = '0;
    logic [31:0] preset_val = '0;

    logic        r3_valid = 1'b0;
    logic        r3_ready;
    logic [1:0]  r3_addr = '0;
    logic [1:0]  r3_op = '0;
    logic [31:0] r3_wdata = '0;
    logic        r3_rsp_valid;
    logic        r3_rsp_ready = 1'b1;
    logic [31:0] r3_rdata;
    logic        r3_err;
    logic [2:0]  r3_wr_en;
    logic [31:0] r3_wr_data;

    assign csr_rd_data = {csr_q[3], csr_q[2], csr_q[1], csr_q[0]};

    cve2_csr_rmw_ctrl #(.Width(32), .NumCsr(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_op_i(req_op), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error), .csr_wr_en_o(wr_en), .csr_wr_data_o(wr_data),
        .csr_rd_data_i(csr_rd_data), .csr_rd_error_i(csr_err)
    );

    cve2_csr_rmw_ctrl #(.Width(32), .NumCsr(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(r3_valid), .req_ready_o(r3_ready), .req_addr_i(r3_addr),
        .req_op_i(r3_op), .req_wdata_i(r3_wdata),
        .rsp_valid_o(r3_rsp_valid), .rsp_ready_i(r3_rsp_ready), .rsp_rdata_o(r3_rdata),
        .rsp_error_o(r3_err), .csr_wr_en_o(r3_wr_en), .csr_wr_data_o(r3_wr_data),
        .csr_rd_data_i(R3_DATA), .csr_rd_error_i(3'b000)
    );

    // CSR bank stand-in: plain registers that take the controller's write pulse.
    always @(posedge clk) begin
        if (preset_en) csr_q[preset_idx] <= preset_val;
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k] && !ignore_writes) csr_q[k] <= wr_data;
        end
    end

    // Transaction model state
    logic [31:0] mdl_csr [4];
    bit          busy = 1'b0;
    int          rel = 0;
    int          lat = 1;
    bit          exp_wr = 1'b0;
    logic [1:0]  exp_addr = '0;
    logic [31:0] exp_new = '0;
    logic [31:0] exp_old = '0;
    bit          exp_err = 1'b0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [3:0]  exp_we;
    bit          exp_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                chk("rst_req_ready", req_ready, 1);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_wr_en", wr_en, 0);
            end else begin
                exp_we = (busy && exp_wr && rel == 1) ? (4'b0001 << exp_addr) : 4'b0000;
                chk("wr_en", wr_en, exp_we);
                if (exp_we != 4'b0000) chk("wr_data", wr_data, exp_new);
                chk("req_ready", req_ready, !busy);
                exp_vld = busy && (rel >= lat);
                chk("rsp_valid", rsp_valid, exp_vld);
                if (exp_vld) begin
                    chk("rsp_rdata", rsp_rdata, exp_old);
                    chk("rsp_error", rsp_error, exp_err);
                end
            end
        end
        if (wr_en != 4'b0000) pulse_cnt++;
    end

    task automatic preset(input logic [1:0] idx, input logic [31:0] val);
        preset_idx = idx;
        preset_val = val;
        preset_en  = 1'b1;
        @(posedge clk); #1;
        preset_en  = 1'b0;
        mdl_csr[idx] = val;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic do_req(input logic [1:0] a, input logic [1:0] op, input logic [31:0] wd,
                          input int hold, input bit junk);
        exp_addr = a;
        exp_old  = mdl_csr[a];
        exp_err  = csr_err[a];
        case (op)
            OP_WR:   exp_new = wd;
            OP_SET:  exp_new = exp_old | wd;
            OP_CLR:  exp_new = exp_old & ~wd;
            default: exp_new = exp_old;
        endcase
        exp_wr = ((op == OP_WR) || (op != OP_RD && wd != 32'h0)) && !exp_err;
        if (exp_wr && RB && ignore_writes && exp_new != exp_old) exp_err = 1'b1;
        lat = exp_wr ? WR_LAT : 1;
        req_addr  = a;
        req_op    = op;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = 1'b1;
        rel  = 0;
        if (junk) begin
            req_valid = 1'b1;
            req_addr  = a + 2'd1;
            req_op    = OP_WR;
            req_wdata = ~wd;
        end
        while (rel < lat + hold) begin
            @(posedge clk); #1;
            rel++;
        end
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        busy      = 1'b0;
        if (exp_wr && !ignore_writes) mdl_csr[a] = exp_new;
    endtask

    task automatic do_req3(input logic [1:0] a, input logic [1:0] op, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_e, input int exp_pulses);
        int pulses;
        bit got;
        pulses = 0;
        got    = 1'b0;
        r3_addr  = a;
        r3_op    = op;
        r3_wdata = wd;
        r3_valid = 1'b1;
        @(posedge clk); #1;
        r3_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (r3_wr_en != 3'b000) pulses++;
            if (r3_rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("r3_rsp_timeout", got, 1);
        if (got) begin
            chk("r3_rdata", r3_rdata, exp_rd);
            chk("r3_error", r3_err, exp_e);
        end
        chk("r3_pulses", pulses, exp_pulses);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        for (int k = 0; k < 4; k++) mdl_csr[k] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_error", rsp_error, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_data", wr_data, 0);
        for (int k = 0; k < 4; k++) preset(k[1:0], 32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        do_req(2'd1, OP_WR, 32'hDEAD_BEEF, 0, 1'b0);
        chk("write_rdata", last_rdata, 32'h0);
        chk("write_error", last_err, 0);
        chk("write_csr1", csr_q[1], 32'hDEAD_BEEF);

        preset(2'd2, 32'h0000_00F0);
        do_req(2'd2, OP_SET, 32'h0000_000F, 0, 1'b0);
        chk("set_rdata", last_rdata, 32'h0000_00F0);
        chk("set_csr2", csr_q[2], 32'h0000_00FF);
        do_req(2'd2, OP_CLR, 32'h0000_0030, 0, 1'b0);
        chk("clear_rdata", last_rdata, 32'h0000_00FF);
        chk("clear_csr2", csr_q[2], 32'h0000_00CF);

        preset(2'd3, 32'h1234_5678);
        p0 = pulse_cnt;
        do_req(2'd3, OP_RD, 32'hFFFF_FFFF, 0, 1'b0);
        chk("read_rdata", last_rdata, 32'h1234_5678);
        do_req(2'd3, OP_SET, 32'h0, 0, 1'b0);
        do_req(2'd3, OP_CLR, 32'h0, 0, 1'b0);
        chk("nowrite_pulses", pulse_cnt - p0, 0);
        chk("nowrite_csr3", csr_q[3], 32'h1234_5678);
        do_req(2'd3, OP_WR, 32'h0, 0, 1'b0);
        chk("write_zero_csr3", csr_q[3], 32'h0);

        csr_err[0] = 1'b1;
        p0 = pulse_cnt;
        do_req(2'd0, OP_WR, 32'hA5A5_A5A5, 0, 1'b0);
        chk("rderr_error", last_err, 1);
        chk("rderr_pulses", pulse_cnt - p0, 0);
        chk("rderr_csr0", csr_q[0], 32'h0);
        csr_err[0] = 1'b0;

        p0 = pulse_cnt;
        do_req(2'd1, OP_CLR, 32'h0000_FFFF, 10, 1'b1);
        chk("hold_pulses", pulse_cnt - p0, 1);
        chk("hold_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("hold_csr1", csr_q[1], 32'hDEAD_0000);
        chk("hold_csr2_untouched", csr_q[2], 32'h0000_00CF);

        p0 = pulse_cnt;
        req_addr  = 2'd0;
        req_op    = OP_WR;
        req_wdata = 32'h0000_0055;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_pulses", pulse_cnt - p0, 0);
        chk("midrst_csr0", csr_q[0], 32'h0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);

        do_req(2'd1, OP_RD, 32'h0, 0, 1'b0);
        chk("post_rst_read", last_rdata, 32'hDEAD_0000);

`ifdef CVE2_CSR_RMW_READBACK_EN
        ignore_writes = 1'b1;
        do_req(2'd2, OP_WR, 32'h0000_0001, 0, 1'b0);
        chk("readback_error", last_err, 1);
        chk("readback_rdata", last_rdata, 32'h0000_00CF);
        ignore_writes = 1'b0;
`endif

        do_req3(2'd3, OP_RD, 32'h0, 32'h0, 1'b1, 0);
        do_req3(2'd3, OP_WR, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        do_req3(2'd2, OP_SET, 32'h0000_0003, 32'h0000_0033, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cve2_csr_rmw_ctrl.md
Name: cve2_csr_rmw_ctrl

Overview:
Access controller that drives a bank of cve2_csr primitives from the master side. It accepts one CSR request at a time over a valid/ready channel and performs read, write, set or clear as an atomic read-modify-write sequence. It pulses the per-register write enable and returns the old value plus an error flag. The block sits between the CSR instruction decode path and the CSR primitive bank.

Parameters:
Width, 32, data width of each CSR and of the request/response data.
NumCsr, 4, number of attached CSR primitives (>=1). Derived localparam AddrW = max(1, $clog2(NumCsr)).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready (high only in IDLE)
req_addr_i  in  AddrW  target CSR index
req_op_i  in  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR
req_wdata_i  in  Width  write data / bit mask
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_rdata_o  out  Width  CSR value before modification
rsp_error_o  out  1  read-shadow error or bad address
csr_wr_en_o  out  NumCsr  one-hot write enable to CSR primitives
csr_wr_data_o  out  Width  shared write data to CSR primitives
csr_rd_data_i  in  NumCsr*Width  flattened read data; CSR k occupies bits [k*Width +: Width]
csr_rd_error_i  in  NumCsr  per-CSR shadow mismatch flags

Behaviour:
- Reset (asynchronous, active-low, rst_ni; clock clk_i): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, csr_wr_en_o=0, csr_wr_data_o=0. All latched fields are cleared.
- States: IDLE, READ, WRITE, [VERIFY], RESP.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch addr, op and wdata, then go to READ. Nothing else is registered.
- READ, one cycle: capture old=csr_rd_data_i[addr] and err=csr_rd_error_i[addr].
  - Compute new value: WRITE gives wdata; SET gives old|wdata; CLEAR gives old&~wdata.
  - Write needed when op==WRITE, or when op is SET/CLEAR and wdata!=0. READ never writes.
  - If addr>=NumCsr: err=1, old=0, no write.
  - If err=1: write is suppressed and the state goes to RESP.
  - If a write is needed: go to WRITE. Otherwise go to RESP.
- WRITE, one cycle: csr_wr_en_o[addr]=1 and csr_wr_data_o=new, both registered outputs. Go to RESP, or to VERIFY when the optional feature is enabled. csr_wr_en_o is all-zero in every other state. csr_wr_data_o holds its last value.
- RESP: rsp_valid_o=1, rsp_rdata_o=old, rsp_error_o=err. These stay stable until rsp_ready_i. On rsp_valid_o&&rsp_ready_i, go to IDLE and drop rsp_valid_o the next cycle.
- Latency, request accepted at edge N:
  - Write path: wr_en high in cycle N+2, rsp_valid_o in cycle N+3.
  - No-write path: rsp_valid_o in cycle N+2.
- Throughput: at most one outstanding request. The next request is accepted no earlier than the cycle after the response handshake.
- Back-pressure: rsp_ready_i held low keeps RESP indefinitely. No second write occurs.
- Reset mid-operation: the sequence aborts immediately and no wr_en pulse is emitted after reset asserts. A pending response is discarded.
- req_* inputs are ignored outside IDLE.
- Assert: csr_wr_en_o is one-hot or zero. req_valid_i is known after reset.

Optional Feature:
Macro CVE2_CSR_RMW_READBACK_EN.
- Defined: WRITE goes to VERIFY. In VERIFY, one cycle after the write, the block compares csr_rd_data_i[addr] with the written value and samples csr_rd_error_i[addr]. A mismatch or a set error flag ORs err=1. Write-path response latency becomes N+4. rsp_rdata_o remains the old value.
- Not defined: the VERIFY state does not exist and WRITE goes directly to RESP.

Test Plan:
- Reset, then a WRITE addr 1 with wdata 0xDEADBEEF -> csr_wr_en_o=4'b0010 for one cycle at N+2, csr_wr_data_o=0xDEADBEEF. Response at N+3: rdata=prior value 0, error=0.
- CSR2=0x0000_00F0; SET with mask 0x0000_000F -> write 0x0000_00FF, rdata=0x0000_00F0. Then CLEAR with mask 0x0000_0030 -> write 0x0000_00CF, rdata=0x0000_00FF.
- READ addr 3, and SET addr 3 with mask 0 -> no wr_en pulse, rsp_valid_o at N+2, rdata=CSR3 value.
- csr_rd_error_i[0]=1 during a WRITE to addr 0 -> no wr_en pulse, rsp_error_o=1. With NumCsr=3, addr 3 -> error=1, rdata=0.
- rsp_ready_i held low for 10 cycles -> rsp_valid_o and rdata stay stable, req_ready_o=0, exactly one wr_en pulse.
- rst_ni asserted in the READ cycle of a WRITE -> csr_wr_en_o stays 0, rsp_valid_o=0, req_ready_o=1 after reset deasserts.
- With CVE2_CSR_RMW_READBACK_EN defined and the CSR model forced to ignore writes: WRITE 0x1 -> rsp_error_o=1 at N+4.
